traffic_phase_timer: RTL and testbench

- Upstream timing stage for the UK traffic-lights sequencer.
- Observes the sequencer's red/amber/green outputs and issues a one-cycle advance pulse. The sequencer steps to its next phase on the clk edge that ends a cycle where advance is high.
- Sets per-phase dwell times and serves pedestrian requests by extending red, with a walk indication.
- Detects illegal or stuck light states.

---
 rtl/traffic_pkg.sv | 37 +++
 rtl/traffic_phase_decode.sv | 32 +++
 rtl/traffic_phase_timer.sv | 158 +++++++++++++++
 tb/tb_traffic_phase_timer.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_pkg
// Description : Shared phase encoding, timer FSM states and the legal
//               phase-successor function for the traffic phase timer.
// Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

  // Light phases as seen on {red,amber,green}
  typedef enum logic [1:0] {
    RED       = 2'd0,
    RED_AMBER = 2'd1,
    GREEN     = 2'd2,
    AMBER     = 2'd3
  } phase_t;

  // Timer FSM states
  typedef enum logic [1:0] {
    SYNC     = 2'd0,
    COUNT    = 2'd1,
    WAIT_CHG = 2'd2,
    ERROR    = 2'd3
  } state_t;

  // Legal successor of a phase in the UK sequence
  function automatic phase_t next_phase(input phase_t p);
    case (p)
      RED:       next_phase = RED_AMBER;
      RED_AMBER: next_phase = GREEN;
      GREEN:     next_phase = AMBER;
      default:   next_phase = RED;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_phase_decode.sv
`default_nettype none
// ============================================================================
// Module      : traffic_phase_decode
// Description : Combinational decode of the sequencer's {red,amber,green}
//               lights into a phase code plus a legal flag.
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_phase_decode
  import traffic_pkg::*;
(
  input  logic   i_red,
  input  logic   i_amber,
  input  logic   i_green,
  output phase_t o_phase,
  output logic   o_legal
);

  // Map the four legal light patterns; anything else is flagged illegal
  always_comb begin
    o_phase = RED;
    o_legal = 1'b0;
    case ({i_red, i_amber, i_green})
      3'b100: begin o_phase = RED;       o_legal = 1'b1; end
      3'b110: begin o_phase = RED_AMBER; o_legal = 1'b1; end
      3'b001: begin o_phase = GREEN;     o_legal = 1'b1; end
      3'b010: begin o_phase = AMBER;     o_legal = 1'b1; end
      default: begin o_phase = RED;      o_legal = 1'b0; end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/traffic_phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : traffic_phase_timer
// Description : Timing stage for the UK traffic-lights sequencer. Watches the
//               lights, times each phase, pulses advance, serves pedestrian
//               requests by extending red and flags illegal/stuck lights.
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_phase_timer
  import traffic_pkg::*;
#(
  parameter int RED_CYCLES       = 8,
  parameter int RED_AMBER_CYCLES = 2,
  parameter int GREEN_CYCLES     = 6,
  parameter int AMBER_CYCLES     = 3,
  parameter int PED_EXTRA_CYCLES = 4,
  parameter int CNT_W            = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic red,
  input  logic amber,
  input  logic green,
  input  logic ped_req,
  output logic advance,
  output logic walk,
  output logic ped_ack,
  output logic phase_err
);

  phase_t w_phase;
  logic   w_legal;

  traffic_phase_decode u_decode (
    .i_red   (red),
    .i_amber (amber),
    .i_green (green),
    .o_phase (w_phase),
    .o_legal (w_legal)
  );

  state_t             r_state;
  phase_t             r_phase;
  // Number of cycles of the current phase already completed; the cycle
  // being observed right now is therefore r_cnt+1.
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ped_pending;
  logic               r_served;
  logic               r_advance;
  logic               r_walk;
  logic               r_ped_ack;
  logic               r_phase_err;

  // Dwell length of a phase; a served red carries the pedestrian extension
  function automatic logic [CNT_W-1:0] dwell(input phase_t p, input logic served);
    case (p)
      RED:       dwell = served ? CNT_W'(RED_CYCLES + PED_EXTRA_CYCLES)
                                : CNT_W'(RED_CYCLES);
      RED_AMBER: dwell = CNT_W'(RED_AMBER_CYCLES);
      GREEN:     dwell = CNT_W'(GREEN_CYCLES);
      default:   dwell = CNT_W'(AMBER_CYCLES);
    endcase
  endfunction

  logic [CNT_W-1:0] w_cur_cycle;
  logic [CNT_W-1:0] w_cur_dwell;
  logic [CNT_W-1:0] w_new_dwell;
  logic             w_same;
  logic             w_succ;
  logic             w_serve;
  logic             w_fault;

  assign w_cur_cycle = r_cnt + 1'b1;
  assign w_cur_dwell = dwell(r_phase, r_served);
  // Dwell of the phase being entered; r_served already reflects the
  // pedestrian decision taken at the end of the preceding amber.
  assign w_new_dwell = dwell(w_phase, r_served);
  assign w_same      = w_legal && (w_phase == r_phase);
  assign w_succ      = w_legal && (w_phase == next_phase(r_phase));
  // A request in the last amber cycle still catches the coming red
  assign w_serve     = r_ped_pending | ped_req;
  assign w_fault     = ((r_state == COUNT)    && !w_same) ||
                       ((r_state == WAIT_CHG) && !w_succ);

  // Phase FSM, dwell counter, pedestrian latch and registered outputs.
  // advance is registered, so it is raised one edge early to be visible
  // in the D-th cycle of the phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= SYNC;
      r_phase       <= RED;
      r_cnt         <= '0;
      r_ped_pending <= 1'b0;
      r_served      <= 1'b0;
      r_advance     <= 1'b0;
      r_walk        <= 1'b0;
      r_ped_ack     <= 1'b0;
      r_phase_err   <= 1'b0;
    end else if (w_fault || (r_state == ERROR)) begin
      r_state     <= ERROR;
      r_advance   <= 1'b0;
      r_walk      <= 1'b0;
      r_ped_ack   <= 1'b0;
      r_phase_err <= 1'b1;
    end else begin
      r_ped_pending <= r_ped_pending | ped_req;
      r_ped_ack     <= 1'b0;
      case (r_state)
        SYNC: begin
          if (w_legal) begin
            r_state   <= COUNT;
            r_phase   <= w_phase;
            r_cnt     <= CNT_W'(1);
            r_advance <= (w_new_dwell == CNT_W'(2));
          end
        end
        COUNT: begin
          if (w_cur_cycle == w_cur_dwell) begin
            r_state   <= WAIT_CHG;
            r_advance <= 1'b0;
            if (r_phase == AMBER) begin
              // Red is next: decide now so walk/ped_ack appear in its cycle 1
              r_served  <= w_serve;
              r_walk    <= w_serve;
              r_ped_ack <= w_serve;
              if (w_serve) begin
                r_ped_pending <= 1'b0;
              end
            end else begin
              r_served <= 1'b0;
              r_walk   <= 1'b0;
            end
          end else begin
            r_cnt     <= w_cur_cycle;
            r_advance <= (w_cur_cycle == (w_cur_dwell - 1'b1));
          end
        end
        WAIT_CHG: begin
          // Reaching here without a fault means the legal successor is shown
          r_state   <= COUNT;
          r_phase   <= w_phase;
          r_cnt     <= CNT_W'(1);
          r_advance <= (w_new_dwell == CNT_W'(2));
        end
        default: begin
          r_state <= ERROR;
        end
      endcase
    end
  end

  assign advance   = r_advance;
  assign walk      = r_walk;
  assign ped_ack   = r_ped_ack;
  assign phase_err = r_phase_err;

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_phase_timer
// Description : Self-checking bench. A behavioural sequencer steps on
//               advance; a phase-level reference model predicts outputs from
//               visible-cycle counts and pedestrian rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_phase_timer;

  localparam int RC  = 8;
  localparam int RAC = 2;
  localparam int GC  = 6;
  localparam int AC  = 3;
  localparam int PX  = 4;

  logic clk = 1'b0;
  logic rst, red, amber, green, ped_req;
  logic advance, walk, ped_ack, phase_err;

  always #5 clk = ~clk;

  traffic_phase_timer #(
    .RED_CYCLES(RC), .RED_AMBER_CYCLES(RAC), .GREEN_CYCLES(GC),
    .AMBER_CYCLES(AC), .PED_EXTRA_CYCLES(PX), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .red(red), .amber(amber), .green(green),
    .ped_req(ped_req), .advance(advance), .walk(walk), .ped_ack(ped_ack),
    .phase_err(phase_err)
  );

  int checks = 0;
  int errors = 0;

  // Sequencer / reference model state. Phases: 0 RED,1 RED_AMBER,2 GREEN,3 AMBER
  int seq = 0;           // phase currently shown
  int vis = 1;           // cycles the shown phase has been visible (this one incl.)
  bit pending = 0;       // model pedestrian request
  bit served  = 0;       // current red is served
  bit err_exp = 0;       // error expected to be flagged
  bit jumped  = 0;       // this phase was entered by a non-successor jump
  bit ignore_adv = 0;    // sequencer ignores the next advance
  int jump_to = -1;      // next step goes here instead of the successor
  int ped_pct = 0;       // random ped_req probability (percent)
  int ped_ph = -1, ped_vis = -1;      // one-shot directed ped pulse
  int force_ph = -1, force_vis = -1;  // one-shot 111 injection
  int adv_cnt = 0, walk_cnt = 0, ack_cnt = 0;

  // One entry per completed phase
  int hist_ph[$], hist_len[$], hist_adv[$], hist_walk[$], hist_ack[$];

  function automatic int dwell(input int p, input bit s);
    case (p)
      0: return s ? RC + PX : RC;
      1: return RAC;
      2: return GC;
      default: return AC;
    endcase
  endfunction

  function automatic logic [2:0] lights(input int p);
    case (p)
      0: return 3'b100;
      1: return 3'b110;
      2: return 3'b001;
      default: return 3'b010;
    endcase
  endfunction

  // One clock cycle: drive inputs, compare outputs, let the sequencer react
  task automatic cycle(input bit r);
    int d;
    bit bad, ea, ew, ek, adv_s;
    logic [2:0] shown;
    if (vis == 1 && seq == 0) begin
      served  = pending;
      pending = 1'b0;
    end
    shown = lights(seq);
    if (force_ph == seq && force_vis == vis) begin
      shown    = 3'b111;
      force_ph = -1;
    end
    rst     = r;
    ped_req = 1'b0;
    if (ped_pct > 0 && $urandom_range(99) < ped_pct) ped_req = 1'b1;
    if (ped_ph == seq && ped_vis == vis) begin
      ped_req = 1'b1;
      ped_ph  = -1;
    end
    {red, amber, green} = shown;
    d   = dwell(seq, served);
    bad = (shown == 3'b111) || (vis > d) || jumped;
    ea  = !err_exp && (vis == d);
    ew  = !err_exp && (seq == 0) && served;
    ek  = ew && (vis == 1);
    checks += 4;
    if (advance !== ea) begin
      errors++;
      $display("FAIL advance t=%0t phase=%0d vis=%0d: got %b want %b", $time, seq, vis, advance, ea);
    end
    if (walk !== ew) begin
      errors++;
      $display("FAIL walk t=%0t phase=%0d vis=%0d: got %b want %b", $time, seq, vis, walk, ew);
    end
    if (ped_ack !== ek) begin
      errors++;
      $display("FAIL ped_ack t=%0t phase=%0d vis=%0d: got %b want %b", $time, seq, vis, ped_ack, ek);
    end
    if (phase_err !== err_exp) begin
      errors++;
      $display("FAIL phase_err t=%0t phase=%0d vis=%0d: got %b want %b", $time, seq, vis, phase_err, err_exp);
    end
    if (advance === 1'b1) adv_cnt++;
    if (walk === 1'b1) walk_cnt++;
    if (ped_ack === 1'b1) ack_cnt++;
    adv_s = (advance === 1'b1);
    @(posedge clk);
    #1;
    jumped = 1'b0;
    if (adv_s && !ignore_adv) begin
      hist_ph.push_back(seq);
      hist_len.push_back(vis);
      hist_adv.push_back(adv_cnt);
      hist_walk.push_back(walk_cnt);
      hist_ack.push_back(ack_cnt);
      if (jump_to >= 0) begin
        jumped = (jump_to != (seq + 1) % 4);
        seq    = jump_to;
      end else begin
        seq = (seq + 1) % 4;
      end
      jump_to = -1;
      vis = 1;
      adv_cnt = 0; walk_cnt = 0; ack_cnt = 0;
    end else begin
      if (adv_s) ignore_adv = 1'b0;
      vis++;
    end
    if (r) begin
      pending = 1'b0; served = 1'b0; err_exp = 1'b0; jumped = 1'b0; vis = 1;
      adv_cnt = 0; walk_cnt = 0; ack_cnt = 0;
    end else begin
      pending = pending | ped_req;
      if (bad) err_exp = 1'b1;
    end
  endtask

  task automatic do_reset(input int start_phase);
    seq = start_phase;
    rst = 1'b1;
    ped_req = 1'b0;
    {red, amber, green} = lights(seq);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    vis = 1; pending = 0; served = 0; err_exp = 0; jumped = 0;
    ignore_adv = 0; jump_to = -1; ped_ph = -1; force_ph = -1;
    adv_cnt = 0; walk_cnt = 0; ack_cnt = 0;
  endtask

  task automatic run_until(input int p);
    int n;
    n = 0;
    while (!(seq == p && vis == 1) && n < 100) begin
      cycle(1'b0);
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL run_until: phase %0d not reached in 100 cycles (now %0d)", p, seq);
    end
  endtask

  task automatic run_hist(input int target);
    int n;
    n = 0;
    while (hist_ph.size() < target && n < 300) begin
      cycle(1'b0);
      n++;
    end
    checks++;
    if (hist_ph.size() < target) begin
      errors++;
      $display("FAIL run_hist: got %0d phases, want %0d within 300 cycles", hist_ph.size(), target);
    end
  endtask

  task automatic test_reset();
    do_reset(0);
    checks += 4;
    if (advance !== 1'b0)   begin errors++; $display("FAIL reset_advance: got %b want 0", advance); end
    if (walk !== 1'b0)      begin errors++; $display("FAIL reset_walk: got %b want 0", walk); end
    if (ped_ack !== 1'b0)   begin errors++; $display("FAIL reset_ped_ack: got %b want 0", ped_ack); end
    if (phase_err !== 1'b0) begin errors++; $display("FAIL reset_phase_err: got %b want 0", phase_err); end
  endtask

  task automatic test_default_loop();
    int base, sum;
    int exp_len[4];
    exp_len = '{RC, RAC, GC, AC};
    ped_pct = 0;
    base = hist_ph.size();
    run_hist(base + 8);
    sum = 0;
    for (int i = 0; i < 8 && base + i < hist_ph.size(); i++) begin
      checks += 4;
      if (hist_ph[base+i] != i % 4) begin errors++; $display("FAIL loop_phase[%0d]: got %0d want %0d", i, hist_ph[base+i], i % 4); end
      if (hist_len[base+i] != exp_len[i%4]) begin errors++; $display("FAIL loop_len[%0d]: got %0d want %0d", i, hist_len[base+i], exp_len[i%4]); end
      if (hist_adv[base+i] != 1) begin errors++; $display("FAIL loop_adv_count[%0d]: got %0d want 1", i, hist_adv[base+i]); end
      if (hist_walk[base+i] != 0) begin errors++; $display("FAIL loop_walk[%0d]: got %0d want 0", i, hist_walk[base+i]); end
      if (i >= 4) sum += hist_len[base+i];
    end
    checks++;
    if (sum != 19) begin errors++; $display("FAIL loop_period: got %0d want 19", sum); end
  endtask

  task automatic test_ped_green();
    int base;
    run_until(2);
    ped_ph = 2; ped_vis = 2;
    base = hist_ph.size();
    run_hist(base + 7);
    if (hist_ph.size() >= base + 7) begin
      checks += 8;
      if (hist_ph[base+2] != 0)      begin errors++; $display("FAIL ped_red1_phase: got %0d want 0", hist_ph[base+2]); end
      if (hist_len[base+2] != RC+PX) begin errors++; $display("FAIL ped_red1_len: got %0d want %0d", hist_len[base+2], RC+PX); end
      if (hist_ack[base+2] != 1)     begin errors++; $display("FAIL ped_red1_ack: got %0d want 1", hist_ack[base+2]); end
      if (hist_walk[base+2] != RC+PX) begin errors++; $display("FAIL ped_red1_walk: got %0d want %0d", hist_walk[base+2], RC+PX); end
      if (hist_ph[base+6] != 0)      begin errors++; $display("FAIL ped_red2_phase: got %0d want 0", hist_ph[base+6]); end
      if (hist_len[base+6] != RC)    begin errors++; $display("FAIL ped_red2_len: got %0d want %0d", hist_len[base+6], RC); end
      if (hist_ack[base+6] != 0)     begin errors++; $display("FAIL ped_red2_ack: got %0d want 0", hist_ack[base+6]); end
      if (hist_walk[base+6] != 0)    begin errors++; $display("FAIL ped_red2_walk: got %0d want 0", hist_walk[base+6]); end
    end
  endtask

  task automatic test_ped_in_served_red();
    int base;
    run_until(2);
    ped_ph = 2; ped_vis = 2;
    run_until(0);
    ped_ph = 0; ped_vis = 3;
    base = hist_ph.size();
    run_hist(base + 5);
    if (hist_ph.size() >= base + 5) begin
      for (int k = 0; k < 5; k += 4) begin
        checks += 3;
        if (hist_len[base+k] != RC+PX)  begin errors++; $display("FAIL served_red%0d_len: got %0d want %0d", k, hist_len[base+k], RC+PX); end
        if (hist_ack[base+k] != 1)      begin errors++; $display("FAIL served_red%0d_ack: got %0d want 1", k, hist_ack[base+k]); end
        if (hist_walk[base+k] != RC+PX) begin errors++; $display("FAIL served_red%0d_walk: got %0d want %0d", k, hist_walk[base+k], RC+PX); end
      end
    end
  endtask

  task automatic test_random_ped();
    ped_pct = 20;
    repeat (300) cycle(1'b0);
    ped_pct = 0;
  endtask

  task automatic test_ignore_adv();
    int base;
    do_reset(0);
    run_until(2);
    ignore_adv = 1'b1;
    base = hist_ph.size();
    repeat (12) cycle(1'b0);
    checks += 2;
    if (phase_err !== 1'b1) begin errors++; $display("FAIL ignore_adv_err: got %b want 1", phase_err); end
    if (hist_ph.size() != base) begin errors++; $display("FAIL ignore_adv_steps: got %0d want 0", hist_ph.size() - base); end
  endtask

  task automatic test_illegal();
    do_reset(0);
    run_until(2);
    force_ph = 2; force_vis = 3;
    repeat (3) cycle(1'b0);
    checks++;
    if (phase_err !== 1'b1) begin errors++; $display("FAIL illegal_111_err: got %b want 1", phase_err); end
    repeat (5) cycle(1'b0);
  endtask

  task automatic test_jump();
    do_reset(0);
    jump_to = 2;
    repeat (12) cycle(1'b0);
    checks++;
    if (phase_err !== 1'b1) begin errors++; $display("FAIL jump_err: got %b want 1", phase_err); end
  endtask

  task automatic test_rst_mid();
    int base;
    do_reset(0);
    run_until(2);
    ped_ph = 2; ped_vis = 2;
    repeat (3) cycle(1'b0);
    cycle(1'b1);
    checks += 4;
    if (advance !== 1'b0)   begin errors++; $display("FAIL rstmid_advance: got %b want 0", advance); end
    if (walk !== 1'b0)      begin errors++; $display("FAIL rstmid_walk: got %b want 0", walk); end
    if (ped_ack !== 1'b0)   begin errors++; $display("FAIL rstmid_ped_ack: got %b want 0", ped_ack); end
    if (phase_err !== 1'b0) begin errors++; $display("FAIL rstmid_phase_err: got %b want 0", phase_err); end
    base = hist_ph.size();
    run_hist(base + 3);
    if (hist_ph.size() >= base + 3) begin
      checks += 4;
      if (hist_ph[base] != 2 || hist_len[base] != GC) begin errors++; $display("FAIL rstmid_green: got phase %0d len %0d want phase 2 len %0d", hist_ph[base], hist_len[base], GC); end
      if (hist_len[base+2] != RC)  begin errors++; $display("FAIL rstmid_red_len: got %0d want %0d", hist_len[base+2], RC); end
      if (hist_walk[base+2] != 0)  begin errors++; $display("FAIL rstmid_red_walk: got %0d want 0", hist_walk[base+2]); end
      if (hist_ack[base+2] != 0)   begin errors++; $display("FAIL rstmid_red_ack: got %0d want 0", hist_ack[base+2]); end
    end
  endtask

  initial begin
    test_reset();
    test_default_loop();
    test_ped_green();
    test_ped_in_served_red();
    test_random_ped();
    test_ignore_adv();
    test_illegal();
    test_jump();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete by %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
